// File: rtl/npu_input_fifo_if.sv
// Host/NPU-facing handshake bundle for the NPU input FIFO.
// The slave modport is the FIFO itself; the master modport is whoever drives pushes and pops.
interface npu_input_fifo_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                  npu_input_fifo_flush;
    logic                  npu_input_fifo_write_en;
    logic [DATA_WIDTH-1:0] npu_input_fifo_data_in;
    logic                  npu_input_fifo_read_en;
    logic [DATA_WIDTH-1:0] npu_input_fifo_data_out;
    logic                  npu_input_fifo_empty;
    logic                  npu_input_fifo_full;
    logic                  npu_input_fifo_almost_full;
    logic [ADDR_WIDTH:0]   npu_input_fifo_count;
    logic                  npu_input_fifo_overflow;
    logic                  npu_input_fifo_underflow;

    modport master (
        output npu_input_fifo_flush,
        output npu_input_fifo_write_en,
        output npu_input_fifo_data_in,
        output npu_input_fifo_read_en,
        input  npu_input_fifo_data_out,
        input  npu_input_fifo_empty,
        input  npu_input_fifo_full,
        input  npu_input_fifo_almost_full,
        input  npu_input_fifo_count,
        input  npu_input_fifo_overflow,
        input  npu_input_fifo_underflow
    );

    modport slave (
        input  npu_input_fifo_flush,
        input  npu_input_fifo_write_en,
        input  npu_input_fifo_data_in,
        input  npu_input_fifo_read_en,
        output npu_input_fifo_data_out,
        output npu_input_fifo_empty,
        output npu_input_fifo_full,
        output npu_input_fifo_almost_full,
        output npu_input_fifo_count,
        output npu_input_fifo_overflow,
        output npu_input_fifo_underflow
    );
endinterface

// File: rtl/npu_input_fifo.sv
// Single-clock operand FIFO in front of the NPU state machine, with occupancy,
// almost-full back-pressure and sticky overflow/underflow debug flags.
module npu_input_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 14
) (
    input logic             CLK,
    input logic             RST_N,
    npu_input_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_CNT    = AF_THRESH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  empty_w;
    logic                  full_w;
    logic                  push_ok;
    logic                  pop_ok;

    // Flags decode the registered count, so acceptance always uses pre-edge occupancy.
    assign empty_w = (count == '0);
    assign full_w  = (count == DEPTH_CNT);
    assign push_ok = bus.npu_input_fifo_write_en && !full_w;
    assign pop_ok  = bus.npu_input_fifo_read_en && !empty_w;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.npu_input_fifo_flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr     <= rd_ptr + 1'b1;
                data_out_q <= mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.npu_input_fifo_write_en && full_w) begin
                overflow_q <= 1'b1;
            end
            if (bus.npu_input_fifo_read_en && empty_w) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Storage is never cleared; writes are suppressed in reset and flush cycles.
    always_ff @(posedge CLK) begin
        if (RST_N && !bus.npu_input_fifo_flush && push_ok) begin
            mem[wr_ptr] <= bus.npu_input_fifo_data_in;
        end
    end

    assign bus.npu_input_fifo_data_out    = data_out_q;
    assign bus.npu_input_fifo_empty       = empty_w;
    assign bus.npu_input_fifo_full        = full_w;
    assign bus.npu_input_fifo_almost_full = (count >= AF_CNT);
    assign bus.npu_input_fifo_count       = count;
    assign bus.npu_input_fifo_overflow    = overflow_q;
    assign bus.npu_input_fifo_underflow   = underflow_q;
endmodule

// File: tb/tb_npu_input_fifo.sv
// Self-checking bench for npu_input_fifo: directed boundary steps plus a random
// handshake phase, all compared against a queue-based reference model.
module tb_npu_input_fifo;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    always #5 CLK = ~CLK;

    npu_input_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    npu_input_fifo #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_THRESH (AF)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    int test_count = 0;
    int fail_count = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_dout = '0;
    logic          model_ovf  = 1'b0;
    logic          model_unf  = 1'b0;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_count++;
        assert (got === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        int  n;
        n = model_q.size();
        checkValue({tag, ".count"},       32'(bus.npu_input_fifo_count),       32'(n));
        checkValue({tag, ".empty"},       32'(bus.npu_input_fifo_empty),       32'(n == 0));
        checkValue({tag, ".full"},        32'(bus.npu_input_fifo_full),        32'(n == DEPTH));
        checkValue({tag, ".almost_full"}, 32'(bus.npu_input_fifo_almost_full), 32'(n >= AF));
        checkValue({tag, ".data_out"},    32'(bus.npu_input_fifo_data_out),    32'(model_dout));
        checkValue({tag, ".overflow"},    32'(bus.npu_input_fifo_overflow),    32'(model_ovf));
        checkValue({tag, ".underflow"},   32'(bus.npu_input_fifo_underflow),   32'(model_unf));
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, then check.
    task automatic applyStimulus(input logic rst_n, input logic flush, input logic we,
                                 input logic [DW-1:0] din, input logic re, input string tag);
        bit was_full;
        bit was_empty;
        RST_N                       = rst_n;
        bus.npu_input_fifo_flush    = flush;
        bus.npu_input_fifo_write_en = we;
        bus.npu_input_fifo_data_in  = din;
        bus.npu_input_fifo_read_en  = re;
        @(posedge CLK);
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        if (!rst_n) begin
            model_q.delete();
            model_dout = '0;
            model_ovf  = 1'b0;
            model_unf  = 1'b0;
        end else if (flush) begin
            model_q.delete();
            model_ovf = 1'b0;
            model_unf = 1'b0;
        end else begin
            if (we && was_full)  model_ovf = 1'b1;
            if (re && was_empty) model_unf = 1'b1;
            if (re && !was_empty) model_dout = model_q.pop_front();
            if (we && !was_full)  model_q.push_back(din);
        end
        #1;
        checkOutput(tag);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bus.npu_input_fifo_flush    = 1'b0;
        bus.npu_input_fifo_write_en = 1'b0;
        bus.npu_input_fifo_data_in  = '0;
        bus.npu_input_fifo_read_en  = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0, "reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, "post_reset");

        for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 1'b0, 1'b1, 16'(i), 1'b0, "fill");
        for (int i = 0; i < 16; i++)  applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, "drain");
        checkValue("drain_last_word", 32'(bus.npu_input_fifo_data_out), 32'h0010);

        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b1, 16'($urandom), 1'b0, "wrap_push10");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, "wrap_pop10");
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 1'b1, 16'hA000 + 16'(i), 1'b0, "wrap_push12");
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, "wrap_pop12");
        checkValue("wrap_last_word", 32'(bus.npu_input_fifo_data_out), 32'hA00B);

        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 1'b1, 16'($urandom), 1'b0, "refill");
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h5555, 1'b1, "full_push_pop");
        checkValue("full_push_pop.count15", 32'(bus.npu_input_fifo_count), 32'd15);
        checkValue("full_push_pop.ovf_set", 32'(bus.npu_input_fifo_overflow), 32'd1);
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, "drain_after_full");

        applyStimulus(1'b1, 1'b0, 1'b1, 16'h7777, 1'b1, "empty_push_pop");
        checkValue("empty_push_pop.count1", 32'(bus.npu_input_fifo_count), 32'd1);
        checkValue("empty_push_pop.unf_set", 32'(bus.npu_input_fifo_underflow), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, "pop_7777");
        checkValue("pop_7777.data", 32'(bus.npu_input_fifo_data_out), 32'h7777);

        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b1, 16'h3000 + 16'(i), 1'b0, "pre_flush");
        applyStimulus(1'b1, 1'b1, 1'b1, 16'hDEAD, 1'b1, "flush");
        checkValue("flush.data_hold", 32'(bus.npu_input_fifo_data_out), 32'h7777);
        checkValue("flush.unf_clear", 32'(bus.npu_input_fifo_underflow), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, "post_flush");

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1, 16'h4000 + 16'(i), 1'b0, "pre_reset_push");
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, "pop_burst");
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, "reset_mid_pop");
        checkValue("reset_mid_pop.data_zero", 32'(bus.npu_input_fifo_data_out), 32'h0000);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'hAAAA, 1'b0, "post_reset_push_a");
        applyStimulus(1'b1, 1'b0, 1'b1, 16'hBBBB, 1'b1, "post_reset_push_pop");
        checkValue("post_reset.first_word", 32'(bus.npu_input_fifo_data_out), 32'hAAAA);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, "post_reset_pop_b");
        checkValue("post_reset.second_word", 32'(bus.npu_input_fifo_data_out), 32'hBBBB);

        for (int i = 0; i < 200; i++) begin
            logic we;
            logic re;
            we = 1'($urandom_range(0, 1));
            re = (model_q.size() != 0) && (1'($urandom_range(0, 1)));
            applyStimulus(1'b1, 1'b0, we, 16'($urandom), re, "random_handshake");
        end
        checkValue("random_handshake.no_underflow", 32'(bus.npu_input_fifo_underflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end
endmodule
